// File: rtl/uart_tx_arbiter.sv
// Two-port round-robin arbiter sharing one UART transmitter, with registered
// strobe/data forwarding, per-port busy flags and a burst limit.
module uart_tx_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              txena0,
  input  logic              txena1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic              txbusy,
  output logic              gnt0,
  output logic              gnt1,
  output logic              txbusy0,
  output logic              txbusy1,
  output logic              txena,
  output logic [DATA_W-1:0] txdata,
  output logic              err,
  output logic [2:0]        arb_leds
);

  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                txena_q, txena_d;
  logic [DATA_W-1:0]   txdata_q, txdata_d;
  logic                err_q, err_d;

  logic quiet_c;
  logic limit0_c, limit1_c;
  logic accept0_c, accept1_c;

  // Busy also covers the handoff window once the burst limit is hit, so the
  // owner cannot slip in a byte while the grant is being passed over.
  always_comb begin
    quiet_c   = ~txena_q & ~txbusy;
    limit0_c  = (state_q == OWN0) & (cnt_q == CNT_MAX) & req1;
    limit1_c  = (state_q == OWN1) & (cnt_q == CNT_MAX) & req0;
    txbusy0   = ~gnt0_q | txbusy | txena_q | limit0_c;
    txbusy1   = ~gnt1_q | txbusy | txena_q | limit1_c;
    accept0_c = gnt0_q & req0 & txena0 & ~txbusy0;
    accept1_c = gnt1_q & req1 & txena1 & ~txbusy1;
  end

  // Next-state, counter, forwarding and error logic.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    txena_d  = accept0_c | accept1_c;
    txdata_d = txdata_q;
    err_d    = err_q | (txena0 & ~accept0_c) | (txena1 & ~accept1_c);

    if (accept0_c) begin
      txdata_d = data0;
    end else if (accept1_c) begin
      txdata_d = data1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0 & (~req1 | last_q)) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (quiet_c & (~req0 | ((cnt_q == CNT_MAX) & req1))) begin
          state_d = IDLE;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (accept0_c & (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OWN1: begin
        if (quiet_c & (~req1 | ((cnt_q == CNT_MAX) & req0))) begin
          state_d = IDLE;
          last_d  = 1'b1;
          cnt_d   = '0;
        end else if (accept1_c & (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Grant trails entry into ownership by a cycle but drops on the release edge.
    gnt0_d = (state_q == OWN0) & (state_d == OWN0);
    gnt1_d = (state_q == OWN1) & (state_d == OWN1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      txena_q  <= 1'b0;
      txdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      txena_q  <= txena_d;
      txdata_q <= txdata_d;
      err_q    <= err_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign txena    = txena_q;
  assign txdata   = txdata_q;
  assign err      = err_q;
  assign arb_leds = {err_q, gnt1_q, gnt0_q};

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic against a rule-level reference model.
module tb_uart_tx_arbiter;

  localparam int DW   = 8;
  localparam int HOLD = 4;

  logic          clk, rst;
  logic          req0, req1, txena0, txena1, txbusy;
  logic [DW-1:0] data0, data1, txdata;
  logic          gnt0, gnt1, txbusy0, txbusy1, txena, err;
  logic [2:0]    arb_leds;

  uart_tx_arbiter #(.DATA_W(DW), .HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .txena0(txena0), .txena1(txena1), .data0(data0), .data1(data1),
    .txbusy(txbusy), .gnt0(gnt0), .gnt1(gnt1), .txbusy0(txbusy0),
    .txbusy1(txbusy1), .txena(txena), .txdata(txdata), .err(err),
    .arb_leds(arb_leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART stand-in: busy rises the cycle after txena and lasts busy_len cycles.
  int busy_len = 3;
  int bc;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bc     <= 0;
      txbusy <= 1'b0;
    end else if (txena) begin
      bc     <= busy_len - 1;
      txbusy <= 1'b1;
    end else if (bc > 0) begin
      bc     <= bc - 1;
      txbusy <= 1'b1;
    end else begin
      txbusy <= 1'b0;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(input bit port, input logic val, output int cyc);
    cyc = 0;
    while (((port ? gnt1 : gnt0) !== val) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_gnt%0d: timeout waiting for %0b", port, val);
    end
  endtask

  // Reference model: who owns, whether the grant is visible yet, bytes sent.
  int          m_own;
  int          m_burst;
  bit          m_gr, m_last, m_txena, m_err;
  logic [7:0]  m_txdata;

  task automatic model_init();
    m_own = -1; m_burst = 0; m_gr = 0; m_last = 1;
    m_txena = 0; m_err = 0; m_txdata = 8'h00;
  endtask

  function automatic logic m_busy(input int p);
    logic g, other;
    g     = (m_own == p) && m_gr;
    other = (p == 0) ? req1 : req0;
    return !g || txbusy || m_txena || ((m_own == p) && (m_burst >= HOLD) && other);
  endfunction

  task automatic model_step();
    bit acc0, acc1, quiet, rq, ro;
    acc0  = (m_own == 0) && m_gr && req0 && txena0 && !m_busy(0);
    acc1  = (m_own == 1) && m_gr && req1 && txena1 && !m_busy(1);
    quiet = !m_txena && !txbusy;
    if (acc0) m_txdata = data0;
    else if (acc1) m_txdata = data1;
    if ((txena0 && !acc0) || (txena1 && !acc1)) m_err = 1;
    if (m_own < 0) begin
      m_gr = 0; m_burst = 0;
      if (req0 && req1) m_own = m_last ? 0 : 1;
      else if (req0) m_own = 0;
      else if (req1) m_own = 1;
    end else begin
      rq = (m_own == 0) ? req0 : req1;
      ro = (m_own == 0) ? req1 : req0;
      if (quiet && (!rq || (m_burst >= HOLD && ro))) begin
        m_last = (m_own == 1); m_own = -1; m_gr = 0; m_burst = 0;
      end else begin
        m_gr = 1;
        if ((m_own == 0 && acc0) || (m_own == 1 && acc1))
          m_burst = (m_burst + 1 > HOLD) ? HOLD : m_burst + 1;
      end
    end
    m_txena = acc0 || acc1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req0 = 0; req1 = 0; txena0 = 0; txena1 = 0; data0 = 0; data1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_init();
  endtask

  typedef struct {
    logic r0, r1, e0, e1;
    logic [7:0] d0, d1;
    logic g0, g1, te;
    logic [7:0] td;
    logic er, b0, b1;
  } vec_t;

  vec_t tv[12];

  initial begin
    int cyc, i0, i1, at_switch;
    bit seen1;
    logic [7:0] exp_q[$];
    logic [7:0] obs[$];

    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, i0, i1, at_switch;
    bit seen1;
    logic [7:0] exp_q[$];
    logic [7:0] obs[$];

    //             r0 r1 e0 e1 d0     d1     g0 g1 te td     er b0 b1
    tv[0]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,1'b1};
    tv[1]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1};
    tv[2]  = '{1'b1,1'b0,1'b1,1'b0,8'hA5,8'h00,1'b1,1'b0,1'b1,8'hA5,1'b0,1'b1,1'b1};
    tv[3]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,1'b0,8'hA5,1'b0,1'b1,1'b1};
    tv[4]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,1'b0,8'hA5,1'b0,1'b1,1'b1};
    tv[5]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,1'b0,8'hA5,1'b0,1'b1,1'b1};
    tv[6]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,1'b0,8'hA5,1'b0,1'b0,1'b1};
    tv[7]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,1'b0,8'hA5,1'b0,1'b1,1'b1};
    tv[8]  = '{1'b0,1'b1,1'b1,1'b0,8'h5A,8'h00,1'b0,1'b0,1'b0,8'hA5,1'b1,1'b1,1'b1};
    tv[9]  = '{1'b0,1'b1,1'b0,1'b0,8'h00,8'h00,1'b0,1'b1,1'b0,8'hA5,1'b1,1'b1,1'b0};
    tv[10] = '{1'b0,1'b1,1'b0,1'b1,8'h00,8'h3C,1'b0,1'b1,1'b1,8'h3C,1'b1,1'b1,1'b1};
    tv[11] = '{1'b0,1'b1,1'b0,1'b1,8'h00,8'h77,1'b0,1'b1,1'b0,8'h3C,1'b1,1'b1,1'b1};

    // Reset values while reset is held.
    rst = 1'b0;
    req0 = 0; req1 = 0; txena0 = 0; txena1 = 0; data0 = 0; data1 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 32'({gnt0, gnt1, txena, txdata, err, txbusy0, txbusy1, arb_leds}),
          32'({1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'b000}));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req0 = tv[i].r0; req1 = tv[i].r1; txena0 = tv[i].e0; txena1 = tv[i].e1;
      data0 = tv[i].d0; data1 = tv[i].d1;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            32'({gnt0, gnt1, txena, txdata, err, txbusy0, txbusy1}),
            32'({tv[i].g0, tv[i].g1, tv[i].te, tv[i].td, tv[i].er, tv[i].b0, tv[i].b1}));
      check($sformatf("leds%0d", i), 32'(arb_leds), 32'({tv[i].er, tv[i].g1, tv[i].g0}));
    end

    // Asynchronous reset while port 1 owns and err is set.
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", 32'({gnt0, gnt1, txena, txdata, err, txbusy0, txbusy1, arb_leds}),
          32'({1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'b000}));
    do_reset();

    // Tie-break and round robin.
    @(negedge clk);
    req0 = 1; req1 = 1;
    wait_gnt(1'b0, 1'b1, cyc);
    check("tie_lat", 32'(cyc), 32'd2);
    check("tie_p1_off", 32'(gnt1), 32'd0);
    req0 = 0;
    wait_gnt(1'b0, 1'b0, cyc);
    check("release_lat", 32'(cyc), 32'd1);
    wait_gnt(1'b1, 1'b1, cyc);
    check("switch_gap", 32'(cyc), 32'd2);
    req0 = 1;
    repeat (3) @(negedge clk);
    check("p1_holds", 32'({gnt0, gnt1}), 32'b01);
    req1 = 0;
    wait_gnt(1'b1, 1'b0, cyc);
    wait_gnt(1'b0, 1'b1, cyc);
    check("rr_to_p0", 32'(cyc), 32'd2);
    req0 = 0;
    wait_gnt(1'b0, 1'b0, cyc);
    @(negedge clk);
    req0 = 1; req1 = 1;
    wait_gnt(1'b1, 1'b1, cyc);
    check("rr_tie_p1", 32'(cyc), 32'd2);
    check("rr_tie_p0_off", 32'(gnt0), 32'd0);
    req0 = 0; req1 = 0;
    wait_gnt(1'b1, 1'b0, cyc);

    // Burst limit: port 0 offers 6 bytes while port 1 keeps requesting.
    do_reset();
    for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
    exp_q.push_back(8'hB0);
    exp_q.push_back(8'hB1);
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h06);
    i0 = 0; i1 = 0; seen1 = 0; at_switch = -1;
    @(negedge clk);
    req0 = 1; req1 = 1;
    for (int c = 0; c < 400 && obs.size() < 8; c++) begin
      @(negedge clk);
      txena0 = 0; txena1 = 0;
      if (txena) obs.push_back(txdata);
      if (gnt1 && !seen1) begin
        seen1 = 1;
        at_switch = obs.size();
      end
      if (i1 == 2 && req1) req1 = 0;
      if (gnt0 && !txbusy0 && i0 < 6) begin
        txena0 = 1; data0 = 8'(i0 + 1); i0++;
      end
      if (gnt1 && !txbusy1 && req1 && i1 < 2) begin
        txena1 = 1; data1 = 8'hB0 + 8'(i1); i1++;
      end
    end
    check("burst_count", 32'(obs.size()), 32'd8);
    for (int k = 0; k < 8 && k < obs.size(); k++)
      check($sformatf("burst_byte%0d", k), 32'(obs[k]), 32'(exp_q[k]));
    check("burst_switch", 32'(at_switch), 32'd4);
    check("burst_err", 32'(err), 32'd0);
    @(negedge clk);
    txena0 = 0; txena1 = 0; req0 = 0; req1 = 0;
    wait_gnt(1'b0, 1'b0, cyc);

    // Randomized traffic against the reference model.
    for (int r = 0; r < 4; r++) begin
      busy_len = $urandom_range(1, 4);
      do_reset();
      for (int c = 0; c < 400; c++) begin
        check("rand", 32'({gnt0, gnt1, txena, txdata, err, txbusy0, txbusy1}),
              32'({(m_own == 0) && m_gr, (m_own == 1) && m_gr, m_txena, m_txdata, m_err,
                   m_busy(0), m_busy(1)}));
        txena0 = (gnt0 && !txbusy0 && req0 && ($urandom_range(0, 1) == 1)) ||
                 ($urandom_range(0, 59) == 0);
        txena1 = (gnt1 && !txbusy1 && req1 && ($urandom_range(0, 1) == 1)) ||
                 ($urandom_range(0, 59) == 0);
        data0 = 8'($urandom);
        data1 = 8'($urandom);
        if (!txena0 && $urandom_range(0, 15) == 0) req0 = ~req0;
        if (!txena1 && $urandom_range(0, 15) == 0) req1 = ~req1;
        model_step();
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
